// File: rtl/ex_muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide share one controller, sign fix-up and result registers.
module ex_muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1,
  parameter int DIV_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             stallreq_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic             div_by_zero_o
);

  localparam int N_MUL = WIDTH / MUL_STEP;
  localparam int N_DIV = WIDTH / DIV_STEP;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_MUL = CNT_W'(N_MUL - 1);
  localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(N_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               op_div, neg_q, neg_r;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic             accept, is_div_in, signed_in, a_neg_in, b_neg_in, div_zero_in, last_step;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  logic [WIDTH+MUL_STEP-1:0] mul_sum;
  logic [2*WIDTH-1:0]        mul_next, prod_fix;
  logic [WIDTH-1:0]          rem_work, quo_work, quo_fix, rem_fix;
  logic [WIDTH:0]            rem_shift, diff;

  assign accept      = (state == IDLE) && start_i && !annul_i;
  assign is_div_in   = op_i[1];
  assign signed_in   = ~op_i[0];
  assign a_neg_in    = signed_in & opa_i[WIDTH-1];
  assign b_neg_in    = signed_in & opb_i[WIDTH-1];
  assign a_mag_in    = a_neg_in ? -opa_i : opa_i;
  assign b_mag_in    = b_neg_in ? -opb_i : opb_i;
  assign div_zero_in = accept && is_div_in && (opb_i == '0);
  assign last_step   = op_div ? (cnt == LAST_DIV) : (cnt == LAST_MUL);

  // Stall covers the accepting cycle and all of CALC; DONE releases the pipeline.
  assign stallreq_o = accept || (state == CALC);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = div_zero_in ? DONE : CALC;
      CALC: begin
        if (annul_i)        state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One multiply step: add multiplicand times the low MUL_STEP multiplier bits, then shift right.
  always_comb begin
    mul_sum = {{MUL_STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]}
            + ({{MUL_STEP{1'b0}}, a_mag} * {{WIDTH{1'b0}}, acc[MUL_STEP-1:0]});
  end

  generate
    if (MUL_STEP == WIDTH) begin : g_mul_full
      assign mul_next = mul_sum;
    end else begin : g_mul_part
      assign mul_next = {mul_sum, acc[WIDTH-1:MUL_STEP]};
    end
  endgenerate

  // Restoring divide: dividend bits leave the top of the quotient register as quotient bits enter below.
  always_comb begin
    rem_work  = rem;
    quo_work  = acc[WIDTH-1:0];
    rem_shift = '0;
    diff      = '0;
    for (int i = 0; i < DIV_STEP; i++) begin
      rem_shift = {rem_work, quo_work[WIDTH-1]};
      diff      = rem_shift - {1'b0, b_mag};
      if (diff[WIDTH]) rem_work = rem_shift[WIDTH-1:0];
      else             rem_work = diff[WIDTH-1:0];
      quo_work = {quo_work[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  assign prod_fix = neg_q ? -mul_next : mul_next;
  assign quo_fix  = neg_q ? -quo_work : quo_work;
  assign rem_fix  = neg_r ? -rem_work : rem_work;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      a_mag         <= '0;
      b_mag         <= '0;
      op_div        <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      acc           <= '0;
      rem           <= '0;
      busy_o        <= 1'b0;
      ready_o       <= 1'b0;
      result_hi_o   <= '0;
      result_lo_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      busy_o  <= (state_next == CALC);
      ready_o <= (state_next == DONE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            a_mag  <= a_mag_in;
            b_mag  <= b_mag_in;
            op_div <= is_div_in;
            neg_q  <= a_neg_in ^ b_neg_in;
            neg_r  <= a_neg_in;
            rem    <= '0;
            acc    <= {{WIDTH{1'b0}}, is_div_in ? a_mag_in : b_mag_in};
            if (div_zero_in) begin
              result_lo_o   <= '1;
              result_hi_o   <= opa_i;
              div_by_zero_o <= 1'b1;
            end
          end
        end
        CALC: begin
          if (!annul_i) begin
            cnt <= cnt + CNT_W'(1);
            if (op_div) begin
              rem              <= rem_work;
              acc[WIDTH-1:0]   <= quo_work;
            end else begin
              acc <= mul_next;
            end
            if (last_step) begin
              div_by_zero_o <= 1'b0;
              if (op_div) begin
                result_hi_o <= rem_fix;
                result_lo_o <= quo_fix;
              end else begin
                {result_hi_o, result_lo_o} <= prod_fix;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: three step configurations against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int W  = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]   op_s;
  logic [W-1:0] opa_s, opb_s;
  logic         start_v [NI];
  logic         annul_v [NI];
  logic         stall_v [NI];
  logic         busy_v  [NI];
  logic         ready_v [NI];
  logic         dbz_v   [NI];
  logic [W-1:0] hi_v    [NI];
  logic [W-1:0] lo_v    [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(W), .MUL_STEP(1), .DIV_STEP(1)) dut0 (
    .clk(clk), .rst(rst), .start_i(start_v[0]), .op_i(op_s), .opa_i(opa_s), .opb_i(opb_s),
    .annul_i(annul_v[0]), .stallreq_o(stall_v[0]), .busy_o(busy_v[0]), .ready_o(ready_v[0]),
    .result_hi_o(hi_v[0]), .result_lo_o(lo_v[0]), .div_by_zero_o(dbz_v[0]));

  ex_muldiv_unit #(.WIDTH(W), .MUL_STEP(4), .DIV_STEP(2)) dut1 (
    .clk(clk), .rst(rst), .start_i(start_v[1]), .op_i(op_s), .opa_i(opa_s), .opb_i(opb_s),
    .annul_i(annul_v[1]), .stallreq_o(stall_v[1]), .busy_o(busy_v[1]), .ready_o(ready_v[1]),
    .result_hi_o(hi_v[1]), .result_lo_o(lo_v[1]), .div_by_zero_o(dbz_v[1]));

  ex_muldiv_unit #(.WIDTH(W), .MUL_STEP(32), .DIV_STEP(1)) dut2 (
    .clk(clk), .rst(rst), .start_i(start_v[2]), .op_i(op_s), .opa_i(opa_s), .opb_i(opb_s),
    .annul_i(annul_v[2]), .stallreq_o(stall_v[2]), .busy_o(busy_v[2]), .ready_o(ready_v[2]),
    .result_hi_o(hi_v[2]), .result_lo_o(lo_v[2]), .div_by_zero_o(dbz_v[2]));

  function automatic int mul_step_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  function automatic int div_step_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int exp_lat(input int k, input logic [1:0] op, input logic [W-1:0] b);
    if (op[1] && b == '0) return 1;
    if (op[1])            return W / div_step_of(k) + 1;
    return W / mul_step_of(k) + 1;
  endfunction

  // Reference results from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    longint sa, sb, q, r;
    logic [63:0] p;
    dbz = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          lo = '1; hi = a; dbz = 1'b1;
        end else if (op == 2'b11) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Holds a request like EX does until ready_o, recording latency and stall/busy behaviour.
  task automatic applyStimulus(input int k, input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, output int lat, output logic [W-1:0] hi,
                               output logic [W-1:0] lo, output logic dbz, output bit ctl_ok);
    op_s = op; opa_s = a; opb_s = b; start_v[k] = 1'b1;
    lat = -1; ctl_ok = 1'b1; hi = '0; lo = '0; dbz = 1'b0;
    for (int c = 0; c < 80 && lat < 0; c++) begin
      #1;
      if (ready_v[k]) begin
        lat = c; hi = hi_v[k]; lo = lo_v[k]; dbz = dbz_v[k];
        if (stall_v[k] || busy_v[k]) ctl_ok = 1'b0;
      end else begin
        if (!stall_v[k] || (busy_v[k] != (c != 0))) ctl_ok = 1'b0;
        @(negedge clk);
      end
    end
    start_v[k] = 1'b0;
  endtask

  task automatic runOp(input int k, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string tag);
    int lat;
    bit ctl_ok;
    logic [W-1:0] hi, lo, ehi, elo;
    logic dbz, edbz;
    applyStimulus(k, op, a, b, lat, hi, lo, dbz, ctl_ok);
    model(op, a, b, ehi, elo, edbz);
    checkOutput({tag, " hilo"}, {hi, lo}, {ehi, elo});
    checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat(k, op, b)));
    checkOutput({tag, " dbz"}, 64'(dbz), 64'(edbz));
    checkOutput({tag, " stall/busy"}, 64'(ctl_ok), 64'd1);
    @(negedge clk); #1;
    checkOutput({tag, " single pulse"}, {62'd0, ready_v[k], busy_v[k]}, 64'd0);
  endtask

  task automatic runKilled(input int k, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int kill_cyc, input bit use_rst,
                           output bit ready_seen, output bit busy_at_kill,
                           output logic [2:0] ctl_after, output logic [W-1:0] hi,
                           output logic [W-1:0] lo, output logic dbz);
    op_s = op; opa_s = a; opb_s = b; start_v[k] = 1'b1;
    ready_seen = 1'b0; busy_at_kill = 1'b0;
    for (int c = 0; c <= kill_cyc; c++) begin
      #1;
      if (ready_v[k]) ready_seen = 1'b1;
      if (c == kill_cyc) begin
        busy_at_kill = busy_v[k];
        if (use_rst) rst = 1'b1;
        else         annul_v[k] = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0; annul_v[k] = 1'b0; start_v[k] = 1'b0;
    #1;
    ctl_after = {busy_v[k], ready_v[k], stall_v[k]};
    hi = hi_v[k]; lo = lo_v[k]; dbz = dbz_v[k];
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (ready_v[k]) ready_seen = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit rs, bk;
    logic [2:0] ctl;
    logic [W-1:0] hi, lo, a, b;
    logic dbz;
    logic [1:0] op;
    int k;

    rst = 1'b1; op_s = '0; opa_s = '0; opb_s = '0;
    for (int i = 0; i < NI; i++) begin start_v[i] = 1'b0; annul_v[i] = 1'b0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("reset hilo dut%0d", i), {hi_v[i], lo_v[i]}, 64'd0);
      checkOutput($sformatf("reset ctl dut%0d", i),
                  {60'd0, busy_v[i], ready_v[i], dbz_v[i], stall_v[i]}, 64'd0);
    end

    runOp(0, 2'b11, 32'd100, 32'd7, "DIVU 100/7");
    runOp(0, 2'b10, -32'sd7, 32'd2, "DIV -7/2");
    runOp(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "DIV overflow");

    for (int i = 0; i < NI; i++) begin
      runOp(i, 2'b00, 32'hFFFF_FFFF, 32'd2, $sformatf("MULT dut%0d", i));
      runOp(i, 2'b01, 32'hFFFF_FFFF, 32'd2, $sformatf("MULTU dut%0d", i));
    end

    runOp(0, 2'b11, 32'd5, 32'd0, "DIVU 5/0");
    runOp(0, 2'b01, 32'd3, 32'd3, "MULTU 3x3 after dbz");

    runOp(0, 2'b11, 32'd100, 32'd7, "DIVU prior");
    runKilled(0, 2'b11, 32'd1000, 32'd3, 10, 1'b0, rs, bk, ctl, hi, lo, dbz);
    checkOutput("annul10 no ready", 64'(rs), 64'd0);
    checkOutput("annul10 busy at kill", 64'(bk), 64'd1);
    checkOutput("annul10 idle after", 64'(ctl), 64'd0);
    checkOutput("annul10 results kept", {hi, lo}, {32'd2, 32'd14});
    checkOutput("annul10 dbz kept", 64'(dbz), 64'd0);
    runOp(0, 2'b11, 32'd9, 32'd3, "DIVU 9/3 after annul");

    runKilled(0, 2'b11, 32'd1000, 32'd3, 20, 1'b1, rs, bk, ctl, hi, lo, dbz);
    checkOutput("rst20 no ready", 64'(rs), 64'd0);
    checkOutput("rst20 busy at kill", 64'(bk), 64'd1);
    checkOutput("rst20 ctl cleared", 64'(ctl), 64'd0);
    checkOutput("rst20 results cleared", {hi, lo}, 64'd0);
    checkOutput("rst20 dbz cleared", 64'(dbz), 64'd0);

    runOp(0, 2'b11, 32'd5, 32'd0, "DIVU 5/0 prior");
    runKilled(0, 2'b11, 32'd1000, 32'd3, 32, 1'b0, rs, bk, ctl, hi, lo, dbz);
    checkOutput("annul32 no ready", 64'(rs), 64'd0);
    checkOutput("annul32 busy at kill", 64'(bk), 64'd1);
    checkOutput("annul32 idle in 33", 64'(ctl), 64'd0);
    checkOutput("annul32 results kept", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    checkOutput("annul32 dbz kept", 64'(dbz), 64'd1);

    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, NI - 1);
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      runOp(k, op, a, b, $sformatf("rand%0d dut%0d op%0d", n, k, op));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed 32-bit radix-2 divider and the separate multiplier with a single block. It supports signed and unsigned MULT/DIV at configurable width and bits-per-cycle, an annul input for pipeline flush, and an explicit divide-by-zero result. EX drives it with held operands and uses `stallreq_o` as its stall request. HI/LO write data comes from `result_hi_o`/`result_lo_o` in the cycle `ready_o` is high.

## Interface
- `WIDTH`, 32: operand width. Results are `WIDTH` bits each for HI and LO.
- `MUL_STEP`, 1: multiplier bits consumed per cycle. Legal values 1, 2, 4 or `WIDTH`, and `WIDTH % MUL_STEP == 0`.
- `DIV_STEP`, 1: quotient bits produced per cycle. Legal values 1 or 2, and `WIDTH % DIV_STEP == 0`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start_i` in 1: request. EX holds it high with stable operands while stalled.
- `op_i` in 2: `00` MULT, `01` MULTU, `10` DIV, `11` DIVU. Sampled at acceptance.
- `opa_i` in WIDTH: multiplicand or dividend.
- `opb_i` in WIDTH: multiplier or divisor.
- `annul_i` in 1: flush. Kills any operation in flight.
- `stallreq_o` out 1: combinational stall request to the stall controller.
- `busy_o` out 1: state is CALC.
- `ready_o` out 1: single-cycle pulse; results are valid this cycle.
- `result_hi_o` out WIDTH: product high half, or remainder.
- `result_lo_o` out WIDTH: product low half, or quotient.
- `div_by_zero_o` out 1: the last completed op was DIV/DIVU with `opb_i == 0`.

## Operation
- FSM states are IDLE, CALC and DONE. Reset puts the FSM in IDLE and clears every output register to 0.
- IDLE, with `start_i & ~annul_i`:
  - Latch |opa| and |opb|; magnitudes are taken only for signed ops.
  - Latch the result signs. Product sign and quotient sign are `a[W-1] ^ b[W-1]`. Remainder sign is `a[W-1]`.
  - Clear the counter and go to CALC.
- Exception in IDLE: for a divide with `opb_i == 0`, go directly to DONE and load these results:
  - `result_lo_o` = all ones.
  - `result_hi_o` = `opa_i`.
  - `div_by_zero_o` = 1.
- CALC, multiply: shift-add into a 2·WIDTH accumulator, `MUL_STEP` multiplier bits per cycle, for N = WIDTH/MUL_STEP cycles.
- CALC, divide: restoring division on a (WIDTH+1)-bit partial remainder, `DIV_STEP` quotient bits per cycle, for N = WIDTH/DIV_STEP cycles.
- Counter wrap: when the counter reaches N−1, go to DONE and apply sign fix-up (two's-complement negate) before the results are registered.
- DONE: `ready_o` = 1 and the results are registered. Next cycle the FSM returns to IDLE unconditionally.
- Result registers hold their value until the next completion; they are not cleared in IDLE.
- Signed overflow case: −2^(W−1) / −1 gives quotient −2^(W−1) (wraps) and remainder 0. There is no exception.
- `stallreq_o` = `(IDLE & start_i & ~annul_i) | CALC`. It is low in DONE, which releases the pipeline in the same cycle that results are valid.
- `start_i` is ignored in CALC and DONE. Operand changes after acceptance are ignored.
- Annul:
  - `annul_i` in CALC or DONE forces IDLE next cycle.
  - `ready_o` is suppressed in that cycle.
  - Result registers and `div_by_zero_o` are left unchanged.
  - `annul_i` in IDLE blocks acceptance.
- `annul_i` has priority over completion. If it is high in the last CALC cycle, the FSM goes to IDLE, not DONE.
- `rst` has priority over everything. Reset mid-operation returns to IDLE with all outputs 0, and no `ready_o` pulse is produced.
- `div_by_zero_o` is updated only on completion. It is 0 for multiply and for a nonzero divisor.

## Timing
- Acceptance edge = cycle 0 (IDLE, request high). CALC occupies cycles 1..N. DONE/`ready_o` is in cycle N+1.
- Total stall: N+1 cycles. Results are consumed at the end of cycle N+1.
- Latency examples:
  - DIV, WIDTH=32, DIV_STEP=1: `ready_o` in cycle 33.
  - MUL_STEP=WIDTH: `ready_o` in cycle 2.
  - Divide by zero: `ready_o` in cycle 1.
- Back-to-back: a new request can be accepted in the IDLE cycle directly after DONE. The minimum issue interval is N+2 cycles.
- `busy_o`, `ready_o`, `result_*`, `div_by_zero_o` are registered (state-decoded). `stallreq_o` is combinational from state, `start_i` and `annul_i`.

## Test plan
- DIVU 100 / 7, WIDTH=32, DIV_STEP=1:
  - `stallreq_o` high for cycles 0..32.
  - `ready_o` only in cycle 33, with `lo` = 14, `hi` = 2, `div_by_zero_o` = 0.
- DIV −7 / 2, then 0x80000000 / 0xFFFFFFFF:
  - First op: `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - Second op: `lo` = 0x80000000, `hi` = 0.
- MULT 0xFFFFFFFF × 2 gives `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFE. MULTU with the same operands gives `hi` = 1, `lo` = 0xFFFFFFFE. Repeat both with MUL_STEP = 1, 4 and 32, checking latencies of 33, 9 and 2 cycles.
- DIVU 5 / 0:
  - `ready_o` in cycle 1, `stallreq_o` high only in cycle 0.
  - `lo` = 0xFFFFFFFF, `hi` = 5, `div_by_zero_o` = 1.
  - Following MULTU 3 × 3 completes with `div_by_zero_o` = 0.
- Annul and reset during DIVU 1000 / 3:
  - `annul_i` in cycle 10: no `ready_o` pulse, IDLE in cycle 11, result registers keep their prior values, and a new DIVU 9 / 3 gives `lo` = 3.
  - Repeat with `rst` in cycle 20: all outputs 0 and no `ready_o` pulse.
- Annul in the last CALC cycle (cycle 32): no `ready_o` pulse, and state is IDLE in cycle 33.
